sm4_group_sched: RTL and testbench
==================================

Name: sm4_group_sched

Overview:
- Sequencer between the UART receive path and the SM4 core.
- Accepts a 384-bit frame (three 128-bit groups) plus key, feeds the core one group at a time over a start/done handshake, and reassembles a 384-bit result for the UART transmitter.
- Replaces the battery-level clock mux with a core clock-enable: the core runs on clk at a rate chosen from the battery level latched at frame accept.

Parameters:
- NUM_BLK, 3, groups per frame.
- BLK_W, 128, group and key width.
- DIV_MID, 4, clock-enable period for battery_level==2.
- DIV_LOW, 8, clock-enable period for battery_level 0 or 3.
- TIMEOUT_CYC, 1024, core_ce ticks allowed per group (optional feature only).

Ports:
- clk  in  1  system clock.
- res  in  1  synchronous reset, active-high.
- frame_valid  in  1  input frame offered.
- frame_ready  out  1  scheduler can accept a frame.
- frame_data  in  NUM_BLK*BLK_W  plaintext; group 0 = MSBs.
- key  in  BLK_W  key, latched with the frame.
- battery_level  in  2  1 = full rate, 2 = mid rate, 0/3 = low rate.
- core_ce  out  1  clock enable for the SM4 core.
- core_start  out  1  start request to the core.
- core_din  out  BLK_W  current group.
- core_key  out  BLK_W  latched key.
- core_done  in  1  core result valid, sampled only when core_ce=1.
- core_dout  in  BLK_W  core result.
- out_valid  out  1  result frame valid.
- out_ready  in  1  transmitter accepts the result.
- out_data  out  NUM_BLK*BLK_W  ciphertext; group 0 = MSBs.
- group_cnt  out  32  total groups completed since reset.
- busy  out  1  high whenever the FSM is not IDLE.

Behaviour:
- Reset (synchronous, res=1 at a clk edge):
  - FSM goes to IDLE.
  - All outputs are 0 except frame_ready=1.
  - group_cnt=0, divider=0, block index=0.
- IDLE:
  - frame_ready=1.
  - On frame_valid&frame_ready: latch frame_data, key and battery_level; clear the divider; go to ISSUE.
- Rate select (from the latched level only; changes during a frame are ignored):
  - Level 1: core_ce=1 every cycle.
  - Level 2: core_ce=1 when divider==DIV_MID-1.
  - Other levels: core_ce=1 when divider==DIV_LOW-1.
  - The divider counts every cycle outside IDLE and wraps to 0 on the same cycle core_ce fires.
  - core_ce=0 in IDLE and OUT.
- ISSUE:
  - core_din = latched group[idx]; core_start=1 is held until a cycle with core_ce=1, which is the last start cycle.
  - Next state is WAIT.
- WAIT:
  - core_start=0.
  - On core_done&core_ce: write core_dout into result slot idx and increment group_cnt (wraps at 2^32).
  - If idx==NUM_BLK-1, go to OUT; otherwise idx+1 and go to ISSUE.
  - A core_done outside WAIT, or with core_ce=0, is ignored.
- OUT:
  - out_valid=1 with stable out_data.
  - On out_ready: idx=0, go to IDLE; frame_ready is high the next cycle.
  - out_valid holds indefinitely while out_ready=0.
- Latency at level 1 with a core latency of L ce-ticks: frame accept to out_valid = NUM_BLK*(L+1)+1 cycles.
- Reset mid-operation: abort immediately; a partial result is never presented and group_cnt returns to 0.
- frame_valid while busy: frame_ready=0 and the frame is not consumed.

Optional Feature:
- Macro: SM4_SCHED_TIMEOUT_EN.
- Defined:
  - A watchdog counts core_ce ticks in WAIT and clears on ISSUE.
  - On reaching TIMEOUT_CYC: pulse output timeout_err for 1 cycle, drop the frame (no out_valid), return to IDLE. group_cnt keeps groups already done.
- Undefined: no watchdog, no timeout_err port; WAIT lasts indefinitely.

Decomposition:
- Package sm4_sched_pkg holds:
  - FSM state encoding IDLE/ISSUE/WAIT/OUT;
  - BLK_W, NUM_BLK defaults;
  - rate codes LVL_FULL=1, LVL_MID=2.
- One sub-module, sm4_rate_div: latched level plus run signal in, core_ce out, divider clear input.

Test Plan:
- Level 1, frame 0x00..01|0x00..02|0x00..03, core model L=4 returning din^key → out_data equals the three XORs, out_valid at cycle 3*5+1=16 after accept, group_cnt=3.
- Level 2 → core_ce period 4. Level 0 → period 8. core_start is never high across two ce ticks. Changing battery_level mid-frame does not change the period.
- out_ready held low 20 cycles → out_valid and out_data stable. frame_valid during that time is not accepted. Accept happens the cycle after out_ready returns to IDLE.
- res=1 in WAIT of group 1 → next cycle IDLE, frame_ready=1, group_cnt=0, core_start=0, no out_valid.
- Spurious core_done in IDLE and with core_ce=0 at level 2 → ignored; group_cnt unchanged.
- SM4_SCHED_TIMEOUT_EN, TIMEOUT_CYC=16, core never done → timeout_err pulse after 16 ce ticks, return to IDLE, no out_valid.

Source files
------------

// File: rtl/sm4_sched_pkg.sv
// Shared encodings and default sizes for the SM4 group scheduler.
package sm4_sched_pkg;

   localparam int DEF_NUM_BLK = 3;
   localparam int DEF_BLK_W   = 128;

   localparam logic [1:0] LVL_FULL = 2'd1;
   localparam logic [1:0] LVL_MID  = 2'd2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      OUT   = 2'd3
   } sched_state_t;

endpackage

// File: rtl/sm4_rate_div.sv
// Core clock-enable divider: the tick period is chosen from the battery level
// latched at frame accept; the counter wraps on the same cycle it ticks.
module sm4_rate_div
   import sm4_sched_pkg::*;
#(
   parameter int DIV_MID = 4,
   parameter int DIV_LOW = 8
) (
   input  logic       clk,
   input  logic       res,
   input  logic [1:0] i_level,
   input  logic       i_count,
   input  logic       i_clr,
   output logic       o_tick
);

   localparam int DW = (DIV_LOW > 2) ? $clog2(DIV_LOW) : 1;

   logic [DW-1:0] r_div;
   logic [DW-1:0] w_top;
   logic          w_wrap;

   // terminal count for the latched rate
   always_comb begin
      w_top = '0;
      case (i_level)
         LVL_FULL: w_top = '0;
         LVL_MID:  w_top = DW'(DIV_MID - 1);
         default:  w_top = DW'(DIV_LOW - 1);
      endcase
   end

   assign w_wrap = (r_div == w_top);
   assign o_tick = i_count & w_wrap;

   // free-running divider, cleared at frame accept
   always_ff @(posedge clk) begin
      if (res) begin
         r_div <= '0;
      end else if (i_clr) begin
         r_div <= '0;
      end else if (i_count) begin
         r_div <= w_wrap ? '0 : r_div + DW'(1);
      end else begin
         r_div <= r_div;
      end
   end

endmodule

// File: rtl/sm4_group_sched.sv
// Feeds a 3-group frame through the SM4 core one group at a time and
// reassembles the result. Optional core watchdog: SM4_SCHED_TIMEOUT_EN.
module sm4_group_sched
   import sm4_sched_pkg::*;
#(
   parameter int NUM_BLK     = DEF_NUM_BLK,
   parameter int BLK_W       = DEF_BLK_W,
   parameter int DIV_MID     = 4,
   parameter int DIV_LOW     = 8
`ifdef SM4_SCHED_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYC = 1024
`endif
) (
   input  logic                     clk,
   input  logic                     res,
   input  logic                     frame_valid,
   output logic                     frame_ready,
   input  logic [NUM_BLK*BLK_W-1:0] frame_data,
   input  logic [BLK_W-1:0]         key,
   input  logic [1:0]               battery_level,
   output logic                     core_ce,
   output logic                     core_start,
   output logic [BLK_W-1:0]         core_din,
   output logic [BLK_W-1:0]         core_key,
   input  logic                     core_done,
   input  logic [BLK_W-1:0]         core_dout,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [NUM_BLK*BLK_W-1:0] out_data,
   output logic [31:0]              group_cnt,
   output logic                     busy
`ifdef SM4_SCHED_TIMEOUT_EN
   ,
   output logic                     timeout_err
`endif
);

   localparam int               IDX_W    = (NUM_BLK > 1) ? $clog2(NUM_BLK) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BLK - 1);

   sched_state_t     r_state;
   sched_state_t     w_next;
   logic [IDX_W-1:0] r_idx;
   logic [BLK_W-1:0] r_grp [NUM_BLK];
   logic [BLK_W-1:0] r_res [NUM_BLK];
   logic [BLK_W-1:0] r_key;
   logic [1:0]       r_lvl;
   logic [31:0]      r_cnt;
   logic             w_accept;
   logic             w_run;
   logic             w_tick;
   logic             w_take;
   logic             w_last;
   logic             w_timeout;

   assign w_accept = frame_valid & (r_state == IDLE);
   assign w_run    = (r_state == ISSUE) | (r_state == WAIT);
   assign w_take   = (r_state == WAIT) & core_done & core_ce;
   assign w_last   = (r_idx == LAST_IDX);

   sm4_rate_div #(
      .DIV_MID (DIV_MID),
      .DIV_LOW (DIV_LOW)
   ) u_rate_div (
      .clk     (clk),
      .res     (res),
      .i_level (r_lvl),
      .i_count (r_state != IDLE),
      .i_clr   (w_accept),
      .o_tick  (w_tick)
   );

   // the divider keeps counting in OUT, but the core is only clocked while a group is in flight
   assign core_ce = w_tick & w_run;

`ifdef SM4_SCHED_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

   logic [WD_W-1:0] r_wd;
   logic            r_to;

   assign w_timeout = (r_state == WAIT) & core_ce & ~core_done &
                      (r_wd == WD_W'(TIMEOUT_CYC - 1));
   assign timeout_err = r_to;

   // counts core ticks spent waiting on one group
   always_ff @(posedge clk) begin
      if (res) begin
         r_wd <= '0;
         r_to <= 1'b0;
      end else begin
         r_to <= w_timeout;
         if (r_state != WAIT) begin
            r_wd <= '0;
         end else if (core_ce) begin
            r_wd <= r_wd + WD_W'(1);
         end else begin
            r_wd <= r_wd;
         end
      end
   end
`else
   assign w_timeout = 1'b0;
`endif

   // state register
   always_ff @(posedge clk) begin
      if (res) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // next-state decode
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (frame_valid) w_next = ISSUE;
            else             w_next = IDLE;
         end
         ISSUE: begin
            if (core_ce) w_next = WAIT;
            else         w_next = ISSUE;
         end
         WAIT: begin
            if (w_take)         w_next = w_last ? OUT : ISSUE;
            else if (w_timeout) w_next = IDLE;
            else                w_next = WAIT;
         end
         OUT: begin
            if (out_ready) w_next = IDLE;
            else           w_next = OUT;
         end
         default: w_next = IDLE;
      endcase
   end

   // frame latch, result slots, group index and completion counter
   always_ff @(posedge clk) begin
      if (res) begin
         r_idx <= '0;
         r_key <= '0;
         r_lvl <= '0;
         r_cnt <= '0;
         for (int g = 0; g < NUM_BLK; g++) begin
            r_grp[g] <= '0;
            r_res[g] <= '0;
         end
      end else begin
         if (w_accept) begin
            r_key <= key;
            r_lvl <= battery_level;
            for (int g = 0; g < NUM_BLK; g++) begin
               r_grp[g] <= frame_data[(NUM_BLK-1-g)*BLK_W +: BLK_W];
            end
         end
         if (w_take) begin
            r_res[r_idx] <= core_dout;
            r_cnt        <= r_cnt + 32'd1;
         end
         if (w_take & ~w_last) begin
            r_idx <= r_idx + IDX_W'(1);
         end else if (((r_state == OUT) & out_ready) | w_timeout) begin
            r_idx <= '0;
         end else begin
            r_idx <= r_idx;
         end
      end
   end

   assign frame_ready = (r_state == IDLE);
   assign busy        = (r_state != IDLE);
   assign core_start  = (r_state == ISSUE);
   assign core_din    = r_grp[r_idx];
   assign core_key    = r_key;
   assign out_valid   = (r_state == OUT);
   assign group_cnt   = r_cnt;

   for (genvar g = 0; g < NUM_BLK; g++) begin : g_out
      assign out_data[(NUM_BLK-1-g)*BLK_W +: BLK_W] = r_res[g];
   end

endmodule

// File: tb/tb_sm4_group_sched.sv
// Scoreboard bench for sm4_group_sched: random frames through an XOR core model
// with configurable latency; define SM4_SCHED_TIMEOUT_EN to exercise the watchdog.
`timescale 1ns/1ps
module tb_sm4_group_sched;

   localparam int NB = 3;
   localparam int BW = 128;
   localparam int FW = NB * BW;
`ifdef SM4_SCHED_TIMEOUT_EN
   localparam int TO_CYC = 16;
`endif

   logic          clk = 1'b0;
   logic          res;
   logic          frame_valid;
   logic          frame_ready;
   logic [FW-1:0] frame_data;
   logic [BW-1:0] key;
   logic [1:0]    battery_level;
   logic          core_ce;
   logic          core_start;
   logic [BW-1:0] core_din;
   logic [BW-1:0] core_key;
   logic          core_done;
   logic [BW-1:0] core_dout;
   logic          out_valid;
   logic          out_ready;
   logic [FW-1:0] out_data;
   logic [31:0]   group_cnt;
   logic          busy;
`ifdef SM4_SCHED_TIMEOUT_EN
   logic          timeout_err;
`endif

   always #5 clk = ~clk;

   sm4_group_sched #(
      .NUM_BLK (NB),
      .BLK_W   (BW),
      .DIV_MID (4),
      .DIV_LOW (8)
`ifdef SM4_SCHED_TIMEOUT_EN
      ,
      .TIMEOUT_CYC (TO_CYC)
`endif
   ) dut (
      .clk           (clk),
      .res           (res),
      .frame_valid   (frame_valid),
      .frame_ready   (frame_ready),
      .frame_data    (frame_data),
      .key           (key),
      .battery_level (battery_level),
      .core_ce       (core_ce),
      .core_start    (core_start),
      .core_din      (core_din),
      .core_key      (core_key),
      .core_done     (core_done),
      .core_dout     (core_dout),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data),
      .group_cnt     (group_cnt),
      .busy          (busy)
`ifdef SM4_SCHED_TIMEOUT_EN
      ,
      .timeout_err   (timeout_err)
`endif
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [BW-1:0] rblk();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   function automatic int period_of(input logic [1:0] lvl);
      if (lvl == 2'd1) return 1;
      if (lvl == 2'd2) return 4;
      return 8;
   endfunction

   // Core model: result is din^key, done shows up core_lat ce ticks after start.
   int            core_lat;
   int            ccnt;
   logic          pend;
   logic [BW-1:0] cres;
   logic          spur_en;

   always @(posedge clk) begin
      if (res) begin
         pend <= 1'b0;
      end else if (core_ce) begin
         if (core_start) begin
            pend <= (core_lat != 0);
            ccnt <= core_lat;
            cres <= core_din ^ core_key;
         end else if (pend) begin
            if (ccnt == 1) pend <= 1'b0;
            else           ccnt <= ccnt - 1;
         end
      end
   end

   // spurious done is only raised where the scheduler must ignore it
   assign core_done = (pend && ccnt == 1) || (spur_en && !core_ce);
   assign core_dout = (pend && ccnt == 1) ? cres : {4{32'hDEADBEEF}};

   typedef struct {
      logic [FW-1:0] data;
      logic [31:0]   cnt;
      int            acc;
      int            lat;
   } exp_t;

   exp_t        sbq[$];
   int          cyc = 0;
   logic [31:0] model_cnt = 32'd0;
   int          cur_per = 0;
   int          last_ce = 0;
   logic        prev_start_tick = 1'b0;
   logic        prev_ov = 1'b0;
   int          n_done = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: clock-enable cadence, start pulses and result frames.
   always @(negedge clk) begin
      if (!res) begin
         if (core_ce) begin
            chk("ce_gating", FW'(cur_per != 0 && !out_valid), FW'(1));
            if (cur_per != 0) chk("ce_period", FW'(cyc - last_ce), FW'(cur_per));
            last_ce = cyc;
            if (prev_start_tick) chk("start_two_ticks", FW'(core_start), FW'(0));
            prev_start_tick = core_start;
         end
         if (out_valid) begin
            cur_per = 0;
            chk("ready_while_out", FW'(frame_ready), FW'(0));
            if (sbq.size() == 0) begin
               chk("spurious_out_valid", FW'(out_valid), FW'(0));
            end else begin
               if (!prev_ov && sbq[0].lat >= 0)
                  chk("latency", FW'(cyc - sbq[0].acc), FW'(sbq[0].lat));
               chk("out_data", out_data, sbq[0].data);
               if (out_ready) begin
                  chk("group_cnt", FW'(group_cnt), FW'(sbq[0].cnt));
                  void'(sbq.pop_front());
                  n_done++;
               end
            end
         end
         prev_ov = out_valid;
      end
   end

   // Offer one frame, record its expected result, optionally wait for it.
   task automatic send_frame(input logic [FW-1:0] fd, input logic [BW-1:0] k,
                             input logic [1:0] lvl, input int lat, input int hold,
                             input bit expect_out, output int acc);
      exp_t e;
      int   guard;
      int   done0;
      guard = 0;
      while (!frame_ready && guard < 500) begin
         @(posedge clk); #1;
         guard++;
      end
      chk("ready_before_send", FW'(frame_ready), FW'(1));
      frame_data    = fd;
      key           = k;
      battery_level = lvl;
      core_lat      = lat;
      frame_valid   = 1'b1;
      done0         = n_done;
      @(posedge clk); #1;
      frame_valid = 1'b0;
      acc = cyc;
      chk("accepted", FW'(busy), FW'(1));
      cur_per         = period_of(lvl);
      last_ce         = cyc - 1;
      prev_start_tick = 1'b0;
      for (int g = 0; g < NB; g++)
         e.data[(NB-1-g)*BW +: BW] = fd[(NB-1-g)*BW +: BW] ^ k;
      if (expect_out) begin
         model_cnt = model_cnt + 32'd3;
         e.cnt = model_cnt;
         e.acc = acc;
         // accept cycle is cycle 0, so NB*(L+1)+1 cycles is NB*(L+1) edges later
         e.lat = (lvl == 2'd1) ? NB * (lat + 1) : -1;
         sbq.push_back(e);
      end
      battery_level = 2'($urandom_range(0, 3));
      if (expect_out) begin
         if (hold > 0) begin
            out_ready = 1'b0;
            guard = 0;
            while (!out_valid && guard < 2000) begin
               @(posedge clk); #1;
               guard++;
            end
            frame_valid = 1'b1;
            frame_data  = ~fd;
            repeat (hold) @(posedge clk);
            #1;
            frame_valid = 1'b0;
            out_ready   = 1'b1;
            @(posedge clk); #1;
            @(negedge clk);
            chk("ready_after_out", FW'(frame_ready), FW'(1));
         end
         guard = 0;
         while (n_done == done0 && guard < 2000) begin
            @(posedge clk); #1;
            guard++;
         end
         chk("frame_completed", FW'(n_done - done0), FW'(1));
      end
   endtask

   initial begin
      int            acc;
      int            g;
      logic [1:0]    lvl;
      logic [FW-1:0] fd;
      res           = 1'b1;
      frame_valid   = 1'b0;
      frame_data    = '0;
      key           = '0;
      battery_level = 2'd1;
      out_ready     = 1'b1;
      spur_en       = 1'b0;
      core_lat      = 4;
      repeat (3) @(posedge clk);
      #1 res = 1'b0;
      @(negedge clk);
      chk("rst_frame_ready", FW'(frame_ready), FW'(1));
      chk("rst_out_valid",   FW'(out_valid),   FW'(0));
      chk("rst_core_start",  FW'(core_start),  FW'(0));
      chk("rst_core_ce",     FW'(core_ce),     FW'(0));
      chk("rst_busy",        FW'(busy),        FW'(0));
      chk("rst_group_cnt",   FW'(group_cnt),   FW'(0));
      chk("rst_out_data",    out_data,         FW'(0));
      chk("rst_core_din",    FW'(core_din),    FW'(0));
      @(posedge clk); #1;

      fd = {128'd1, 128'd2, 128'd3};
      send_frame(fd, rblk(), 2'd1, 4, 0, 1'b1, acc);

      spur_en = 1'b1;
      repeat (10) @(posedge clk);
      #1 spur_en = 1'b0;
      @(negedge clk);
      chk("idle_spurious_cnt", FW'(group_cnt), FW'(model_cnt));
      chk("idle_spurious_busy", FW'(busy), FW'(0));
      @(posedge clk); #1;

      spur_en = 1'b1;
      send_frame({rblk(), rblk(), rblk()}, rblk(), 2'd2, 3, 0, 1'b1, acc);
      spur_en = 1'b0;
      send_frame({rblk(), rblk(), rblk()}, rblk(), 2'd0, 2, 0, 1'b1, acc);

      for (int i = 0; i < 10; i++) begin
         lvl     = 2'($urandom_range(0, 3));
         spur_en = (lvl != 2'd1) ? 1'($urandom_range(0, 1)) : 1'b0;
         send_frame({rblk(), rblk(), rblk()}, rblk(), lvl, $urandom_range(1, 6), 0, 1'b1, acc);
         spur_en = 1'b0;
      end

      send_frame({rblk(), rblk(), rblk()}, rblk(), 2'd1, 2, 20, 1'b1, acc);

      send_frame({rblk(), rblk(), rblk()}, rblk(), 2'd1, 4, 0, 1'b0, acc);
      repeat (8) @(posedge clk);
      #1;
      chk("cnt_before_reset", FW'(group_cnt), FW'(model_cnt + 32'd1));
      res = 1'b1;
      @(posedge clk); #1;
      res       = 1'b0;
      cur_per   = 0;
      model_cnt = 32'd0;
      @(negedge clk);
      chk("mid_rst_frame_ready", FW'(frame_ready), FW'(1));
      chk("mid_rst_group_cnt",   FW'(group_cnt),   FW'(0));
      chk("mid_rst_core_start",  FW'(core_start),  FW'(0));
      chk("mid_rst_out_valid",   FW'(out_valid),   FW'(0));
      repeat (10) @(posedge clk);
      #1;
      send_frame({rblk(), rblk(), rblk()}, rblk(), 2'($urandom_range(0, 3)), 3, 0, 1'b1, acc);

`ifdef SM4_SCHED_TIMEOUT_EN
      send_frame({rblk(), rblk(), rblk()}, rblk(), 2'd1, 0, 0, 1'b0, acc);
      g = 0;
      while (!timeout_err && g < 500) begin
         @(negedge clk);
         g++;
      end
      chk("timeout_seen", FW'(timeout_err), FW'(1));
      chk("timeout_time", FW'(cyc - acc), FW'(TO_CYC + 1));
      cur_per = 0;
      @(negedge clk);
      chk("timeout_pulse_width", FW'(timeout_err), FW'(0));
      chk("timeout_idle",        FW'(frame_ready), FW'(1));
      chk("timeout_group_cnt",   FW'(group_cnt),   FW'(model_cnt));
      repeat (5) @(posedge clk);
`else
      g = 0;
`endif

      repeat (5) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL global_timeout: simulation did not finish, checks %0d/%0d", n_pass, n_chk);
      $fatal(1);
   end

endmodule
